// File: rtl/mul_sequencer.sv
// ============================================================================
// Module   : mul_sequencer
// Brief    : Valid/ready front end for the Booth radix-2 multiplier, with a
//            watchdog that aborts a multiplication that never completes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_sequencer #(
    parameter int TIMEOUT = 31,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        mul_start,
    output logic [7:0]  mul_multiplier,
    output logic [7:0]  mul_multiplicand,
    input  logic [15:0] mul_product,
    input  logic        mul_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_product,
    output logic        out_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_WAIT   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_WDOG_LAST = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_a;
    logic [7:0]        r_b;
    logic [15:0]       r_prod;
    logic              r_err;
    logic [CNT_W-1:0]  r_wdog;
    logic              w_done_ok;
    logic              w_timeout;

    // Watchdog is still zero in the first WAIT cycle, which masks a stale done.
    assign w_done_ok = mul_done && (r_wdog != '0);
    assign w_timeout = (r_wdog == c_WDOG_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        mul_start = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                mul_start = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                if (w_done_ok || w_timeout) begin
                    w_next = S_RESULT;
                end
            end
            S_RESULT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
            r_err  <= 1'b0;
            r_wdog <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a <= in_a;
                        r_b <= in_b;
                    end
                end
                S_START: begin
                    r_wdog <= '0;
                end
                S_WAIT: begin
                    r_wdog <= r_wdog + 1'b1;
                    // Done takes priority over a coincident timeout.
                    if (w_done_ok) begin
                        r_prod <= mul_product;
                        r_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_prod <= '0;
                        r_err  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mul_multiplier   = r_a;
    assign mul_multiplicand = r_b;
    assign out_product      = r_prod;
    assign out_err          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mul_sequencer.sv
// ============================================================================
// Module   : tb_mul_sequencer
// Brief    : Self-checking bench for mul_sequencer using a behavioural
//            multiplier stub and an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_sequencer;

    localparam int TIMEOUT = 31;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        mul_start;
    logic [7:0]  mul_multiplier;
    logic [7:0]  mul_multiplicand;
    logic [15:0] mul_product;
    logic        mul_done;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_product;
    logic        out_err;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    // Stub modes: 0 = done N cycles after start falls, 1 = done stuck high, 2 = never done
    int   stub_mode = 0;
    int   stub_n = 4;
    logic stub_act = 1'b0;
    int   stub_cnt = 0;

    mul_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .mul_start        (mul_start),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_product      (mul_product),
        .mul_done         (mul_done),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .out_err          (out_err),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    always @(posedge clk) begin
        if (mul_start) begin
            stub_act <= 1'b1;
            stub_cnt <= 0;
        end else if (!busy || out_valid) begin
            stub_act <= 1'b0;
        end else if (stub_act) begin
            stub_cnt <= stub_cnt + 1;
        end
    end

    assign mul_done    = (stub_mode == 1) || (stub_mode == 0 && stub_act && stub_cnt >= stub_n);
    assign mul_product = mul_done ? ref_mul(mul_multiplier, mul_multiplicand) : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction; bp = cycles of held-off out_ready after out_valid.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input int mode, input int n, input int bp);
        int          waits;
        int          exp_w;
        logic        exp_e;
        logic [15:0] exp_p;
        stub_mode = mode;
        stub_n    = n;
        exp_e = (mode == 2);
        exp_p = exp_e ? 16'h0000 : ref_mul(a, b);
        exp_w = (mode == 2) ? TIMEOUT : ((mode == 1 || n == 0) ? 2 : n + 1);

        @(negedge clk);
        out_ready = (bp == 0);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);

        @(negedge clk);
        in_valid = 1'b0;
        check("start_pulse", mul_start, 1);
        check("start_in_ready", in_ready, 0);
        check("start_busy", busy, 1);
        check("start_mplier", mul_multiplier, a);
        check("start_mcand", mul_multiplicand, b);
        in_a = 8'($urandom);
        in_b = 8'($urandom);

        @(negedge clk);
        check("wait_start_low", mul_start, 0);
        waits = 0;
        while (!out_valid && waits < 200) begin
            waits++;
            in_valid = 1'($urandom);
            @(negedge clk);
        end
        check("wait_cycles", waits, exp_w);
        check("res_product", out_product, exp_p);
        check("res_err", out_err, exp_e);
        check("res_in_ready", in_ready, 0);
        check("res_mplier_held", mul_multiplier, a);
        check("res_mcand_held", mul_multiplicand, b);

        for (int i = 0; i < bp; i++) begin
            in_valid = 1'($urandom);
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_product", out_product, exp_p);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;

        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
    endtask

    initial begin
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_start", mul_start, 0);
        check("rst_product", out_product, 0);
        check("rst_err", out_err, 0);
        check("rst_mplier", mul_multiplier, 0);
        @(negedge clk);
        rst = 1'b1;

        do_op(8'd3,   8'd5,   0, 8, 0);
        do_op(8'hFE,  8'h07,  0, 3, 0);
        do_op(8'h80,  8'h80,  0, 5, 0);
        do_op(8'h00,  8'h7F,  0, 2, 0);
        do_op(8'h55,  8'hAB,  0, 4, 5);
        do_op(8'hC3,  8'h3C,  1, 0, 0);
        do_op(8'h12,  8'h34,  0, 0, 1);
        do_op(8'h21,  8'h43,  2, 0, 0);
        do_op(8'h0B,  8'hF5,  0, 6, 0);

        // Abort an operation mid-WAIT with an asynchronous reset.
        stub_mode = 0;
        stub_n    = 8;
        @(negedge clk);
        in_a = 8'd11;
        in_b = 8'd13;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_start", mul_start, 0);
        check("arst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("arst_no_stale", out_valid, 0);
        end
        do_op(8'd7,  8'd9,  0, 3, 0);
        do_op(8'hFF, 8'hFF, 0, 1, 0);

        for (int i = 0; i < 20; i++) begin
            do_op(8'($urandom), 8'($urandom), 0,
                  int'($urandom_range(0, 10)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Request/response front end that sits directly upstream of the Booth radix-2 multiplier. It accepts signed 8x8 operand pairs over a valid/ready handshake and drives the multiplier's start, multiplier and multiplicand inputs. It waits for the multiplier's done, then captures the 16-bit product and presents it over a valid/ready result handshake. A watchdog flags a multiplier that never completes.

Parameters:
TIMEOUT, 31, max cycles in WAIT before aborting with error (must be >= 10)
CNT_W, 5, width of watchdog counter (must hold TIMEOUT)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  operand pair valid
in_ready  output  1  sequencer can accept operands
in_a  input  8  multiplier operand, two's complement
in_b  input  8  multiplicand operand, two's complement
mul_start  output  1  start to multiplier, one-cycle pulse
mul_multiplier  output  8  operand A to multiplier
mul_multiplicand  output  8  operand B to multiplier
mul_product  input  16  product from multiplier
mul_done  input  1  multiplier done
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_product  output  16  captured product
out_err  output  1  result aborted by watchdog; qualified by out_valid
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; operand regs, out_product, out_err, watchdog = 0; mul_start=0; out_valid=0; in_ready=1 once rst deasserts.
- States: IDLE, START, WAIT, RESULT. All outputs are registered or decoded from state only. No combinational path from in_valid/out_ready/mul_done to any output.
- IDLE: in_ready=1. On in_valid=1, latch in_a/in_b into operand regs, then go to START. Otherwise hold.
- START: mul_start=1 for exactly this cycle. Clear watchdog. Go to WAIT.
- WAIT: mul_start=0. Watchdog increments each cycle.
  - mul_done is ignored in the first WAIT cycle, because the multiplier's counter is still settling from the start pulse.
  - From the second WAIT cycle, mul_done=1 captures mul_product into out_product, sets out_err=0 and goes to RESULT.
  - If the watchdog reaches TIMEOUT without a qualifying done: out_product=0, out_err=1, go to RESULT.
  - If done and timeout occur in the same cycle, done wins (out_err=0).
- RESULT: out_valid=1. out_product and out_err are stable. On out_ready=1, go to IDLE. No new operand is accepted in the same cycle (in_ready=0 in RESULT).
- mul_multiplier and mul_multiplicand continuously reflect the operand regs. They are held stable from START until return to IDLE, because the multiplier reloads the multiplicand every cycle.
- Operand regs change only on the IDLE acceptance edge. in_a/in_b changing at other times has no effect.
- Throughput: one operation in flight. Minimum cycles from accept edge to out_valid = 3 + multiplier latency.
- Reset mid-operation: immediate return to IDLE. Any pending result is discarded. mul_start drops asynchronously.
- mul_done high while in IDLE, START or RESULT: ignored.
- out_ready high while not in RESULT: ignored.

Test Plan:
- Bench uses a behavioural multiplier stub (product = signed a*b, done asserted N cycles after start falls, N configurable). The real multiplier is used in a separate integration run.
- Basic: in_a=3, in_b=5, stub N=8, out_ready=1 -> mul_start high exactly 1 cycle; out_valid with out_product=0x000F, out_err=0; in_ready returns 1 the cycle after the handshake.
- Signed: in_a=0xFE(-2), in_b=0x07 -> out_product=0xFFF2; in_a=0x80, in_b=0x80 -> 0x4000; in_a=0, in_b=0x7F -> 0x0000.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and out_product stable, in_ready=0 throughout, in_valid pulses ignored; out_ready=1 -> single transfer.
- Early/stale done: stub holds mul_done=1 continuously -> done ignored in first WAIT cycle; capture on second WAIT cycle; product correct.
- Watchdog: stub never asserts done, TIMEOUT=31 -> out_valid exactly 31 WAIT cycles after START with out_err=1, out_product=0x0000; next operation completes normally.
- Reset mid-WAIT: drive rst=0 for 1 cycle during WAIT -> out_valid=0, busy=0, mul_start=0 immediately; no stale result afterwards; back-to-back ops 7*9=0x003F then -1*-1=0x0001 succeed.
